// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types and constants for the UART receive control block.
// The state encoding, the error-field layout and the timeout arithmetic live here.
package uart_rx_ctrl_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam int ERR_PAR        = 0;
    localparam int ERR_STP        = 1;
    localparam int FRAME_BITS_MAX = 12;
    localparam int FRAME_W        = 10;

    typedef struct packed {
        logic [1:0] err;
        logic [7:0] data;
    } frame_t;

    // A frame has been on the line too long once the count reaches 12*Prescale - 1.
    function automatic logic [9:0] tmo_limit(input logic [5:0] prescale);
        logic [9:0] w_ext;
        w_ext = {4'b0000, prescale};
        return (w_ext * 10'(FRAME_BITS_MAX)) - 10'd1;
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// System-side read port of the receive FIFO: valid/ready handshake with head data and status.
// The master is the control block; the slave is the consumer.
interface uart_rx_ctrl_if;

    logic       rd_valid;
    logic       rd_ready;
    logic [7:0] rd_data;
    logic [1:0] rd_err;

    modport master (
        output rd_valid,
        output rd_data,
        output rd_err,
        input  rd_ready
    );

    modport slave (
        input  rd_valid,
        input  rd_data,
        input  rd_err,
        output rd_ready
    );

endinterface

// File: rtl/uart_rx_fifo.sv
// Circular frame buffer; pointers are one bit wider than the address to separate full from empty.
// Head is combinational; a push while full only lands when a pop frees the slot in the same cycle.
module uart_rx_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_do_pop;
    logic         w_do_push;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);
    assign head      = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive control: line-activity FSM, between-frame config apply, frame FIFO with overrun flag.
// Push lands 1 cycle after the frame-end event; the read port stalls on rd_ready and frames are dropped when full.
import uart_rx_ctrl_pkg::*;

module uart_rx_ctrl #(
    parameter int         DEPTH        = 4,
    parameter logic [5:0] RST_PRESCALE = 6'd8,
    parameter logic       RST_PAR_EN   = 1'b1,
    parameter logic       RST_PAR_TYP  = 1'b0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  DATA_VALID,
    input  logic [7:0]            P_DATA,
    input  logic                  par_err,
    input  logic                  stp_err,
    output logic [5:0]            Prescale,
    output logic                  PAR_EN,
    output logic                  PAR_TYP,
    input  logic                  cfg_wr,
    input  logic [5:0]            cfg_prescale,
    input  logic                  cfg_par_en,
    input  logic                  cfg_par_typ,
    output logic                  cfg_pending,
    output logic                  cfg_ack,
    uart_rx_ctrl_if.master        rd,
    output logic                  overrun,
    input  logic                  ovr_clr
);

    state_t     r_state, w_state_nxt;
    logic       r_rx_q, r_par_q, r_stp_q, r_done;
    logic [9:0] r_tmo_cnt;
    logic [5:0] r_prescale, r_sh_prescale;
    logic       r_par_en, r_par_typ, r_sh_par_en, r_sh_par_typ;
    logic       r_pending, r_ack, r_ovr;
    logic       w_fall, w_event, w_busy, w_accept, w_timeout, w_apply;
    logic       w_full, w_empty, w_pop, w_drop;
    frame_t     w_push_dat, w_head;

    assign w_fall  = r_rx_q & ~RX_IN;
    assign w_event = DATA_VALID | (par_err & ~r_par_q) | (stp_err & ~r_stp_q);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_fall)                 w_state_nxt = ST_BUSY;
            ST_BUSY: if (w_accept || w_timeout)  w_state_nxt = ST_IDLE;
            default:                             w_state_nxt = ST_IDLE;
        endcase
    end

    // Config may only move while the line is quiet: IDLE and no start bit arriving this cycle.
    always_comb begin
        w_busy    = (r_state == ST_BUSY);
        w_accept  = w_busy & ~r_done & w_event;
        w_timeout = w_busy & (r_tmo_cnt == tmo_limit(r_prescale));
        w_apply   = ~w_busy & r_pending & ~w_fall;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_rx_q    <= 1'b1;
            r_par_q   <= 1'b0;
            r_stp_q   <= 1'b0;
            r_done    <= 1'b0;
            r_tmo_cnt <= '0;
        end else begin
            r_rx_q  <= RX_IN;
            r_par_q <= par_err;
            r_stp_q <= stp_err;
            if (!w_busy && w_fall) begin
                r_tmo_cnt <= '0;
                r_done    <= 1'b0;
            end else if (w_busy) begin
                r_tmo_cnt <= r_tmo_cnt + 10'd1;
                if (w_accept) r_done <= 1'b1;
            end
        end
    end

    // A write in the apply cycle refills the shadow, so pending survives the apply.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_prescale    <= RST_PRESCALE;
            r_par_en      <= RST_PAR_EN;
            r_par_typ     <= RST_PAR_TYP;
            r_sh_prescale <= RST_PRESCALE;
            r_sh_par_en   <= RST_PAR_EN;
            r_sh_par_typ  <= RST_PAR_TYP;
            r_pending     <= 1'b0;
            r_ack         <= 1'b0;
        end else begin
            r_ack <= w_apply;
            if (w_apply) begin
                r_prescale <= r_sh_prescale;
                r_par_en   <= r_sh_par_en;
                r_par_typ  <= r_sh_par_typ;
            end
            if (cfg_wr) begin
                r_sh_prescale <= (cfg_prescale == 6'd0) ? 6'd1 : cfg_prescale;
                r_sh_par_en   <= cfg_par_en;
                r_sh_par_typ  <= cfg_par_typ;
                r_pending     <= 1'b1;
            end else if (w_apply) begin
                r_pending <= 1'b0;
            end
        end
    end

    always_comb begin
        w_push_dat               = '0;
        w_push_dat.data          = P_DATA;
        w_push_dat.err[ERR_PAR]  = par_err;
        w_push_dat.err[ERR_STP]  = stp_err;
    end

    assign w_pop  = rd.rd_valid & rd.rd_ready;
    assign w_drop = w_accept & w_full & ~w_pop;

    uart_rx_fifo #(
        .W     (FRAME_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RST),
        .push  (w_accept),
        .pop   (w_pop),
        .din   (w_push_dat),
        .full  (w_full),
        .empty (w_empty),
        .head  (w_head)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)         r_ovr <= 1'b0;
        else if (w_drop)  r_ovr <= 1'b1;
        else if (ovr_clr) r_ovr <= 1'b0;
    end

    assign rd.rd_valid = ~w_empty;
    assign rd.rd_data  = w_empty ? 8'h00 : w_head.data;
    assign rd.rd_err   = w_empty ? 2'b00 : w_head.err;
    assign Prescale    = r_prescale;
    assign PAR_EN      = r_par_en;
    assign PAR_TYP     = r_par_typ;
    assign cfg_pending = r_pending;
    assign cfg_ack     = r_ack;
    assign overrun     = r_ovr;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: expected frames are queued at stimulus time and
// a negedge monitor pops and compares them whenever the read port handshakes.
module tb_uart_rx_ctrl;
    import uart_rx_ctrl_pkg::*;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic       DATA_VALID = 1'b0;
    logic [7:0] P_DATA = 8'h00;
    logic       par_err = 1'b0;
    logic       stp_err = 1'b0;
    logic       cfg_wr = 1'b0;
    logic [5:0] cfg_prescale = 6'd0;
    logic       cfg_par_en = 1'b0;
    logic       cfg_par_typ = 1'b0;
    logic       ovr_clr = 1'b0;
    logic [5:0] Prescale;
    logic       PAR_EN, PAR_TYP, cfg_pending, cfg_ack, overrun;

    uart_rx_ctrl_if rd ();

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [9:0] sb [$];

    always #5 CLK = ~CLK;

    uart_rx_ctrl #(
        .DEPTH        (4),
        .RST_PRESCALE (6'd8),
        .RST_PAR_EN   (1'b1),
        .RST_PAR_TYP  (1'b0)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_IN        (RX_IN),
        .DATA_VALID   (DATA_VALID),
        .P_DATA       (P_DATA),
        .par_err      (par_err),
        .stp_err      (stp_err),
        .Prescale     (Prescale),
        .PAR_EN       (PAR_EN),
        .PAR_TYP      (PAR_TYP),
        .cfg_wr       (cfg_wr),
        .cfg_prescale (cfg_prescale),
        .cfg_par_en   (cfg_par_en),
        .cfg_par_typ  (cfg_par_typ),
        .cfg_pending  (cfg_pending),
        .cfg_ack      (cfg_ack),
        .rd           (rd.master),
        .overrun      (overrun),
        .ovr_clr      (ovr_clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Start bit, two BUSY cycles, then a one-cycle frame-end stimulus.
    task automatic frame(input logic [7:0] d, input logic pe, input logic se,
                         input logic dv, input logic rdy, input bit exp);
        logic save;
        RX_IN = 1'b0;
        tick(1);
        RX_IN = 1'b1;
        tick(2);
        save       = rd.rd_ready;
        P_DATA     = d;
        DATA_VALID = dv;
        par_err    = pe;
        stp_err    = se;
        if (rdy) rd.rd_ready = 1'b1;
        if (exp) sb.push_back({se, pe, d});
        tick(1);
        DATA_VALID  = 1'b0;
        par_err     = 1'b0;
        stp_err     = 1'b0;
        rd.rd_ready = save;
    endtask

    task automatic cfg_write(input logic [5:0] p, input logic en, input logic typ);
        cfg_wr       = 1'b1;
        cfg_prescale = p;
        cfg_par_en   = en;
        cfg_par_typ  = typ;
        tick(1);
        cfg_wr = 1'b0;
    endtask

    always @(negedge CLK) begin
        logic [9:0] e;
        if (RST && rd.rd_valid && rd.rd_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pop: got %0h/%0h expected no entry", rd.rd_data, rd.rd_err);
            end else begin
                e = sb.pop_front();
                check("rd_data", 32'(rd.rd_data), 32'(e[7:0]));
                check("rd_err", 32'(rd.rd_err), 32'(e[9:8]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ovr_d [5];
        bit         found;
        ovr_d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        rd.rd_ready = 1'b0;

        #12;
        check("rst_rd_valid", 32'(rd.rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd.rd_data), 32'd0);
        check("rst_rd_err", 32'(rd.rd_err), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_cfg_pending", 32'(cfg_pending), 32'd0);
        check("rst_cfg_ack", 32'(cfg_ack), 32'd0);
        check("rst_prescale", 32'(Prescale), 32'd8);
        check("rst_par_en", 32'(PAR_EN), 32'd1);
        check("rst_par_typ", 32'(PAR_TYP), 32'd0);
        @(posedge CLK);
        #1 RST = 1'b1;
        tick(2);

        // Good frame, then a stop-error frame, consumer always ready.
        rd.rd_ready = 1'b1;
        frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("good_valid", 32'(rd.rd_valid), 32'd1);
        tick(1);
        check("good_empty", 32'(rd.rd_valid), 32'd0);
        frame(8'hC3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(2);

        // Parity-error frame; later pulses outside a frame must not push.
        rd.rd_ready = 1'b0;
        frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(1);
        par_err = 1'b1;
        DATA_VALID = 1'b1;
        tick(1);
        par_err = 1'b0;
        DATA_VALID = 1'b0;
        tick(1);
        rd.rd_ready = 1'b1;
        tick(1);
        rd.rd_ready = 1'b0;
        check("par_single", 32'(rd.rd_valid), 32'd0);

        // Overrun: five frames into four slots.
        for (int i = 0; i < 5; i++) frame(ovr_d[i], 1'b0, 1'b0, 1'b1, 1'b0, i < 4);
        check("ovr_set", 32'(overrun), 32'd1);
        ovr_clr = 1'b1;
        tick(1);
        ovr_clr = 1'b0;
        check("ovr_clr", 32'(overrun), 32'd0);
        frame(8'h66, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("ovr_push_pop", 32'(overrun), 32'd0);
        ovr_clr = 1'b1;
        frame(8'h77, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        ovr_clr = 1'b0;
        check("ovr_set_wins", 32'(overrun), 32'd1);
        ovr_clr = 1'b1;
        tick(1);
        ovr_clr = 1'b0;
        check("ovr_clr2", 32'(overrun), 32'd0);
        rd.rd_ready = 1'b1;
        tick(6);
        check("drain_empty", 32'(rd.rd_valid), 32'd0);
        check("drain_sb", 32'(sb.size()), 32'd0);

        // Config written mid-frame waits for the frame end.
        RX_IN = 1'b0;
        tick(1);
        RX_IN = 1'b1;
        cfg_write(6'd16, 1'b0, 1'b1);
        check("busy_prescale", 32'(Prescale), 32'd8);
        check("busy_pending", 32'(cfg_pending), 32'd1);
        tick(3);
        check("busy_hold", 32'(Prescale), 32'd8);
        P_DATA = 8'h5A;
        DATA_VALID = 1'b1;
        sb.push_back({2'b00, 8'h5A});
        tick(1);
        DATA_VALID = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge CLK);
            if (cfg_ack) found = 1'b1;
        end
        check("cfg_ack_seen", 32'(found), 32'd1);
        check("apply_prescale", 32'(Prescale), 32'd16);
        check("apply_par_en", 32'(PAR_EN), 32'd0);
        check("apply_par_typ", 32'(PAR_TYP), 32'd1);
        check("apply_pending", 32'(cfg_pending), 32'd0);
        tick(1);
        check("ack_pulse", 32'(cfg_ack), 32'd0);

        // Earliest apply while IDLE.
        cfg_write(6'd8, 1'b1, 1'b0);
        check("early_ack_lo", 32'(cfg_ack), 32'd0);
        check("early_pending", 32'(cfg_pending), 32'd1);
        tick(1);
        check("early_ack", 32'(cfg_ack), 32'd1);
        check("early_prescale", 32'(Prescale), 32'd8);
        check("early_par_en", 32'(PAR_EN), 32'd1);
        tick(2);

        // Timeout after 96 BUSY cycles at Prescale 8; pending config applied afterwards.
        RX_IN = 1'b0;
        tick(1);
        RX_IN = 1'b1;
        cfg_write(6'd20, 1'b1, 1'b0);
        tick(94);
        check("tmo_not_yet", 32'(cfg_pending), 32'd1);
        check("tmo_hold", 32'(Prescale), 32'd8);
        tick(2);
        check("tmo_ack", 32'(cfg_ack), 32'd1);
        check("tmo_prescale", 32'(Prescale), 32'd20);
        check("tmo_no_push", 32'(rd.rd_valid), 32'd0);
        tick(2);

        // Prescale 0 is applied as 1.
        cfg_write(6'd0, 1'b1, 1'b0);
        tick(1);
        check("zero_prescale", 32'(Prescale), 32'd1);

        // Async reset with entries queued and a config pending.
        rd.rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) frame(8'(i + 1), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        RX_IN = 1'b0;
        tick(1);
        RX_IN = 1'b1;
        cfg_write(6'd30, 1'b0, 1'b1);
        check("pre_rst_valid", 32'(rd.rd_valid), 32'd1);
        check("pre_rst_pending", 32'(cfg_pending), 32'd1);
        #2 RST = 1'b0;
        #1;
        check("arst_rd_valid", 32'(rd.rd_valid), 32'd0);
        check("arst_rd_data", 32'(rd.rd_data), 32'd0);
        check("arst_rd_err", 32'(rd.rd_err), 32'd0);
        check("arst_pending", 32'(cfg_pending), 32'd0);
        check("arst_ack", 32'(cfg_ack), 32'd0);
        check("arst_prescale", 32'(Prescale), 32'd8);
        check("arst_par_en", 32'(PAR_EN), 32'd1);
        check("arst_par_typ", 32'(PAR_TYP), 32'd0);
        tick(1);
        RST = 1'b1;
        tick(3);
        check("post_rst_pending", 32'(cfg_pending), 32'd0);
        check("post_rst_prescale", 32'(Prescale), 32'd8);
        check("final_sb", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Control and buffering block for the UART receive path. It owns the receiver configuration (Prescale, PAR_EN, PAR_TYP) and changes it only between frames. It collects each completed frame (data plus parity/stop error status) into a small FIFO and presents the frames to the system side through a valid/ready read port. It sits between the RX top level (top_RX_module) and the register/bus logic.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, 2..16.
- RST_PRESCALE, 6'd8: Prescale value after reset.
- RST_PAR_EN, 1'b1: PAR_EN value after reset.
- RST_PAR_TYP, 1'b0: PAR_TYP value after reset (0 = even).

Ports:
- CLK  in  1  single clock.
- RST  in  1  asynchronous, active-low reset.
- RX_IN  in  1  serial line, monitored for frame start.
- DATA_VALID  in  1  frame-good pulse from RX.
- P_DATA  in  8  RX parallel data.
- par_err  in  1  RX parity error.
- stp_err  in  1  RX stop error.
- Prescale  out  6  active oversampling ratio to RX.
- PAR_EN  out  1  active parity enable to RX.
- PAR_TYP  out  1  active parity type to RX.
- cfg_wr  in  1  config write strobe.
- cfg_prescale  in  6  requested Prescale.
- cfg_par_en  in  1  requested PAR_EN.
- cfg_par_typ  in  1  requested PAR_TYP.
- cfg_pending  out  1  a config write is waiting to be applied.
- cfg_ack  out  1  one-cycle pulse when the config is applied.
- rd_valid  out  1  FIFO head is valid.
- rd_ready  in  1  consumer accepts the head.
- rd_data  out  8  head data.
- rd_err  out  2  head status {stp_err, par_err}.
- overrun  out  1  sticky; set when a frame is dropped while the FIFO is full.
- ovr_clr  in  1  clears overrun.

## Operation
- Line FSM has two states: IDLE and BUSY.
  - IDLE -> BUSY on an RX_IN falling edge. RX_IN is registered internally for edge detection.
  - BUSY -> IDLE on the frame-end event or on timeout.
- Frame-end event = DATA_VALID | rise(par_err) | rise(stp_err), accepted only in BUSY and at most once per frame. A `done` flag blocks further events until the return to IDLE.
- Timeout: a 10-bit counter runs in BUSY. When it reaches 12*Prescale - 1, the FSM returns to IDLE with no push. The counter clears on entry to BUSY.
- Push on the accepted frame-end event: {stp_err, par_err, P_DATA}, with flags sampled in the same cycle. The FSM then returns to IDLE on the next cycle.
- FIFO: circular, with DEPTH entries and pointers one bit wider than the address so full and empty can be told apart.
  - Pop on rd_valid & rd_ready.
  - Push and pop in the same cycle are both performed, including when the FIFO is full (the entry freed by the pop is reused).
  - Push while full without a pop: the frame is discarded and overrun is set.
  - ovr_clr clears overrun. If ovr_clr coincides with a new overrun, the set wins.
- Config:
  - cfg_wr latches the requested values into a shadow register and sets cfg_pending.
  - A cfg_wr while pending overwrites the shadow (last write wins).
  - Apply when the FSM is in IDLE, pending is set, and no RX_IN falling edge occurs in that cycle. Applying copies shadow -> active, clears pending and pulses cfg_ack.
  - cfg_wr in the apply cycle: the new values go to the shadow and pending stays set.
- Prescale = 0 from cfg is applied as 1. The timeout arithmetic is zero-extended to 10 bits.

## Timing
- Reset values:
  - FSM = IDLE.
  - FIFO empty: rd_valid = 0, rd_data = 0, rd_err = 0.
  - overrun = 0, cfg_pending = 0, cfg_ack = 0.
  - Active config = RST_* parameters.
- rd_data and rd_err come combinationally from the head entry. rd_valid rises 1 cycle after the push.
- Config apply: at the earliest, cfg_ack is high and the outputs change 1 cycle after cfg_wr when the FSM is IDLE. Otherwise this happens in the first eligible IDLE cycle.
- Reset mid-frame or mid-FIFO: everything returns to the reset values immediately and a pending config is lost.

## Structure
- A shared package holds:
  - the state encoding (ST_IDLE, ST_BUSY);
  - the error-field indices (ERR_PAR = 0, ERR_STP = 1);
  - the timeout multiplier constant FRAME_BITS_MAX = 12.
- One sub-module, uart_rx_fifo, parameterised by width (10) and DEPTH. It provides push, pop, full, empty and the head.

## Test plan
- Good frame: Prescale = 8, DATA_VALID with P_DATA = 8'hA5 -> rd_valid with rd_data = A5, rd_err = 00. With rd_ready = 1 the FIFO is empty the next cycle.
- Parity error: par_err rises with P_DATA = 8'h3C and no DATA_VALID -> entry 3C/01. A repeated par_err in the same frame does not push a second entry.
- Overrun: 5 frames pushed with DEPTH = 4 and rd_ready = 0 -> 4 entries are kept and overrun = 1. Push plus pop while full -> no overrun. ovr_clr -> 0.
- Config during a frame: cfg_wr Prescale = 16 while BUSY -> Prescale stays 8 and cfg_pending = 1. After the frame end it changes to 16 with a 1-cycle cfg_ack.
- Timeout: RX_IN falls, then there are no events for 96 cycles at Prescale = 8 -> FSM returns to IDLE, no push, and a pending config is applied.
- Async reset asserted with 3 entries queued and a config pending -> all outputs at reset values and Prescale = 8.
